// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage: data width, fetch
//   FSM state encoding, the canonical NOP encoding and the PC increment.
//   No ports (package).
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int XLEN = 32;

    // Fetch FSM: issue a request, wait for its response, or hold a response
    // that IF/ID could not take yet.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Word-align a fetch address by forcing the two low bits to zero.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage sitting directly upstream of the IF/ID register.
//   Owns the PC, keeps exactly one instruction-memory request outstanding,
//   forwards the response to IF/ID with a single-cycle fire pulse and parks
//   it in a one-entry hold buffer when IF/ID is stalled. A redirect kills
//   whatever fetch is in flight or buffered and restarts at the new PC.
//
//   Ports:
//     clk             in   clock
//     reset_n         in   synchronous, active-low reset
//     out_ready       in   IF/ID can accept an instruction this cycle
//     redirect_valid  in   change the fetch stream this cycle
//     redirect_pc     in   [31:0] new fetch PC (bits [1:0] ignored)
//     imem_req_valid  out  request valid
//     imem_req_ready  in   memory accepts the request
//     imem_req_addr   out  [31:0] request address
//     imem_resp_valid in   response valid (no back-pressure possible)
//     imem_resp_data  in   [31:0] response instruction word
//     imem_resp_fire  out  instruction handed to IF/ID this cycle
//     fetch_inst      out  [31:0] instruction delivered with the fire pulse
//     pc_current      out  [31:0] PC of fetch_inst
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        imem_resp_fire,
    output logic [31:0] fetch_inst,
    output logic [31:0] pc_current
);

    fetch_state_e state;
    fetch_state_e state_next;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            kill_q;
    logic [XLEN-1:0] hold_inst_q;
    logic [XLEN-1:0] hold_pc_q;

    logic req_fire;
    logic hold_load;

    // A request is only ever presented in S_REQ, so the handshake alone
    // identifies an accepted request.
    assign req_fire = imem_req_valid && imem_req_ready;

    // A live response that IF/ID cannot take right now goes into the buffer.
    assign hold_load = (state == S_WAIT) && imem_resp_valid && !kill_q
                       && !redirect_valid && !out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            S_REQ: begin
                if (req_fire) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Any response ends the wait; only a live response that
                // IF/ID refuses is parked in S_HOLD.
                if (imem_resp_valid) begin
                    if (hold_load) begin
                        state_next = S_HOLD;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid || out_ready) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_q;
        imem_resp_fire = 1'b0;
        fetch_inst     = hold_inst_q;
        pc_current     = hold_pc_q;
        unique case (state)
            S_REQ: begin
                imem_req_valid = !redirect_valid;
            end
            S_WAIT: begin
                // Zero-latency pass-through of the memory response.
                if (imem_resp_valid) begin
                    fetch_inst     = imem_resp_data;
                    pc_current     = req_pc_q;
                    imem_resp_fire = !kill_q && !redirect_valid && out_ready;
                end
            end
            S_HOLD: begin
                imem_resp_fire = out_ready && !redirect_valid;
            end
            default: begin
                imem_req_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC tracking. A redirect overrides the sequential increment; it can
    // never coincide with an accepted request because the request valid
    // is suppressed during a redirect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            if (redirect_valid) begin
                pc_q <= align_pc(redirect_pc);
            end else if (req_fire) begin
                pc_q <= pc_q + PC_STEP;
            end
            if (req_fire) begin
                req_pc_q <= pc_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Kill flag: remembers that the outstanding request was made stale by
    // a redirect, so its response must be dropped when it turns up. It can
    // only be set while waiting and is consumed by the response itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kill_q <= 1'b0;
        end else if (state == S_WAIT) begin
            if (imem_resp_valid) begin
                kill_q <= 1'b0;
            end else if (redirect_valid) begin
                kill_q <= 1'b1;
            end
        end else begin
            kill_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // One-entry hold buffer; its contents stay put while IF/ID is stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
        end else if (hold_load) begin
            hold_inst_q <= imem_resp_data;
            hold_pc_q   <= req_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    // Only one request is ever outstanding, so a response outside S_WAIT
    // means the memory misbehaved; it is ignored by the logic above.
    resp_only_when_waiting: assert property (
        @(posedge clk) disable iff (!reset_n)
        imem_resp_valid |-> (state == S_WAIT)
    );

    fire_never_with_redirect: assert property (
        @(posedge clk) disable iff (!reset_n)
        imem_resp_fire |-> !redirect_valid
    );

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Table-driven bench for fetch_unit. Each table row is one clock cycle of
//   stimulus plus the expected request/fire outputs. A behavioural memory
//   answers accepted requests (1-cycle latency, optionally stalled), and a
//   scoreboard queue of {pc, inst} expectations is filled from the table
//   and drained whenever the DUT fires. A second instance with
//   RESET_PC = 32'hFFFF_FFFC checks PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_fire;
    logic [31:0] fetch_inst;
    logic [31:0] pc_current;

    // Second instance (wrap-around check)
    logic        w_out_ready;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_resp_fire;
    logic [31:0] w_fetch_inst;
    logic [31:0] w_pc_current;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .out_ready       (out_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_fire  (imem_resp_fire),
        .fetch_inst      (fetch_inst),
        .pc_current      (pc_current)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk             (clk),
        .reset_n         (reset_n),
        .out_ready       (w_out_ready),
        .redirect_valid  (w_redirect_valid),
        .redirect_pc     (w_redirect_pc),
        .imem_req_valid  (w_req_valid),
        .imem_req_ready  (w_req_ready),
        .imem_req_addr   (w_req_addr),
        .imem_resp_valid (w_resp_valid),
        .imem_resp_data  (w_resp_data),
        .imem_resp_fire  (w_resp_fire),
        .fetch_inst      (w_fetch_inst),
        .pc_current      (w_pc_current)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ordy;
        logic        redir;
        logic [31:0] rpc;
        logic        rrdy;
        logic        rstall;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_fire;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int compared;
    int failed;

    logic        mem_pending;
    logic [31:0] mem_word;

    // Memory contents: a simple address-derived pattern.
    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0013;
    endfunction

    function automatic vec_t mk(input logic rst, input logic ordy,
                                input logic redir, input logic [31:0] rpc,
                                input logic rrdy, input logic rstall,
                                input logic e_rv, input logic [31:0] e_addr,
                                input logic e_fire);
        vec_t v;
        v.rst = rst;   v.ordy = ordy;     v.redir = redir; v.rpc = rpc;
        v.rrdy = rrdy; v.rstall = rstall; v.e_rv = e_rv;   v.e_addr = e_addr;
        v.e_fire = e_fire;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one table row, run the memory model, check outputs and update
    // the scoreboard.
    task automatic applyStimulus(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk);
        reset_n        = !v.rst;
        out_ready      = v.ordy;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        imem_req_ready = v.rrdy;
        if (v.rst) begin
            mem_pending     = 1'b0;
            imem_resp_valid = 1'b0;
            sb.delete();
        end else if (mem_pending && !v.rstall) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word;
            mem_pending     = 1'b0;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        if (!v.rst) begin
            checkOutput($sformatf("row%0d req_valid", idx), {31'b0, imem_req_valid}, {31'b0, v.e_rv});
            if (v.e_rv)
                checkOutput($sformatf("row%0d req_addr", idx), imem_req_addr, v.e_addr);
            checkOutput($sformatf("row%0d fire", idx), {31'b0, imem_resp_fire}, {31'b0, v.e_fire});
            if (imem_resp_fire) begin
                if (sb.size() == 0) begin
                    compared++;
                    failed++;
                    $display("[TB] FAIL row%0d unexpected_fire: got pc %h, expected no fire",
                             idx, pc_current);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("row%0d pc_current", idx), pc_current, e.pc);
                    checkOutput($sformatf("row%0d fetch_inst", idx), fetch_inst, e.inst);
                end
            end
            // Memory accepts the request at the coming edge.
            if (imem_req_valid && imem_req_ready) begin
                mem_pending = 1'b1;
                mem_word    = word_of(imem_req_addr);
            end
            // A redirect kills everything fetched so far.
            if (v.redir)
                sb.delete();
            if (v.e_rv && v.rrdy) begin
                e.pc   = v.e_addr;
                e.inst = word_of(v.e_addr);
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared = 0;
        failed   = 0;
        mem_pending = 1'b0;
        mem_word    = 32'h0;
        reset_n = 1'b0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        w_out_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0;
        w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = 32'h0;

        //             rst ordy rdr rpc        rrdy stl e_rv e_addr     fire
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, 32'h0,     0)); // 0 reset
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0, 32'h0,     0)); // 1
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h0,     0)); // 2 first request
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     1)); // 3 fire 0x0
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h4,     0)); // 4
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0, 32'h0,     0)); // 5 stalled -> hold
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0, 32'h0,     0)); // 6
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0, 32'h0,     0)); // 7
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     1)); // 8 fire 0x4 from hold
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h8,     0)); // 9
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     1)); // 10 fire 0x8
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'hC,     0)); // 11
        vecs.push_back(mk(0, 1, 1, 32'h100,   1, 1, 0, 32'h0,     0)); // 12 redirect in wait
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     0)); // 13 stale resp dropped
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h100,   0)); // 14
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     1)); // 15
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h104,   0)); // 16
        vecs.push_back(mk(0, 1, 1, 32'h203,   1, 0, 0, 32'h0,     0)); // 17 redirect + resp
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h200,   0)); // 18 aligned target
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     1)); // 19
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h204,   0)); // 20
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0, 32'h0,     0)); // 21 -> hold
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0, 32'h0,     0)); // 22
        vecs.push_back(mk(0, 1, 1, 32'h400,   1, 0, 0, 32'h0,     0)); // 23 redirect in hold
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h400,   0)); // 24
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     1)); // 25
        vecs.push_back(mk(0, 1, 0, 32'h0,     0, 0, 1, 32'h404,   0)); // 26 ready low
        vecs.push_back(mk(0, 1, 0, 32'h0,     0, 0, 1, 32'h404,   0)); // 27
        vecs.push_back(mk(0, 1, 0, 32'h0,     0, 0, 1, 32'h404,   0)); // 28
        vecs.push_back(mk(0, 1, 0, 32'h0,     0, 0, 1, 32'h404,   0)); // 29
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h404,   0)); // 30 accepted
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     1)); // 31
        vecs.push_back(mk(0, 1, 1, 32'h800,   1, 0, 0, 32'h0,     0)); // 32 redirect in req
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h800,   0)); // 33
        vecs.push_back(mk(0, 1, 1, 32'h900,   1, 1, 0, 32'h0,     0)); // 34 redirect, no resp
        vecs.push_back(mk(0, 1, 1, 32'hA00,   1, 1, 0, 32'h0,     0)); // 35 repeated redirect
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     0)); // 36 stale resp dropped
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'hA00,   0)); // 37
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     1)); // 38
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'hA04,   0)); // 39
        vecs.push_back(mk(1, 1, 0, 32'h0,     1, 0, 0, 32'h0,     0)); // 40 reset mid-flight
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 1, 32'h0,     0)); // 41 back at RESET_PC
        vecs.push_back(mk(0, 1, 0, 32'h0,     1, 0, 0, 32'h0,     1)); // 42

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(i, vecs[i]);

        compared++;
        if (sb.size() != 0) begin
            failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        // Wrap-around: RESET_PC = FFFF_FFFC, second request must go to 0.
        @(negedge clk);
        reset_n = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        redirect_valid = 1'b0; out_ready = 1'b1;
        w_req_ready = 1'b1; w_resp_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("wrap req_valid0", {31'b0, w_req_valid}, 32'h1);
        checkOutput("wrap req_addr0", w_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        w_resp_valid = 1'b1;
        w_resp_data  = word_of(32'hFFFF_FFFC);
        #1;
        checkOutput("wrap fire", {31'b0, w_resp_fire}, 32'h1);
        checkOutput("wrap pc_current", w_pc_current, 32'hFFFF_FFFC);
        checkOutput("wrap fetch_inst", w_fetch_inst, word_of(32'hFFFF_FFFC));
        @(negedge clk);
        w_resp_valid = 1'b0;
        #1;
        checkOutput("wrap req_valid1", {31'b0, w_req_valid}, 32'h1);
        checkOutput("wrap req_addr1", w_req_addr, 32'h0000_0000);
        @(negedge clk);
        w_req_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
